// File: rtl/pipe_latch_elastic_pkg.sv
// Shared definitions for the elastic inter-stage latch: state encoding and
// default geometry of the DX/XM/MW instances.
package pipe_latch_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 115;
  localparam int unsigned DEF_LANES = 2;

endpackage

// File: rtl/pipe_lane_reg.sv
// One lane slot of the elastic latch: payload plus valid bit.
// clr drops only the valid bit so held payload is left untouched.
module pipe_lane_reg #(
  parameter int unsigned WIDTH = 115
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic LANES-wide pipeline latch with a main + skid slot, registered
// in_ready, flush of all held bundles and per-lane squash at capture.
module pipe_latch_elastic
  import pipe_latch_elastic_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  input  logic [LANES-1:0]       ctrl_squash,
  input  logic                   ctrl_flush,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy
);

  state_t                 state;
  logic [LANES-1:0]       main_valid;
  logic [LANES-1:0]       skid_valid;
  logic [LANES*WIDTH-1:0] main_data;
  logic [LANES*WIDTH-1:0] skid_data;
  logic [LANES-1:0]       keep;
  logic [LANES-1:0]       main_dv;
  logic [LANES*WIDTH-1:0] main_d;
  logic push, pop, store;
  logic main_en, main_clr, skid_en, skid_clr;

  always_comb begin
    keep     = in_valid & ~ctrl_squash;
    push     = (|in_valid) & in_ready & ~ctrl_flush;
    pop      = (|main_valid) & out_ready;
    // a fully squashed bundle still handshakes but occupies no slot
    store    = push & (|keep);
    main_en  = 1'b0;
    skid_en  = 1'b0;
    skid_clr = ctrl_flush;
    main_dv  = keep;
    main_d   = in_data;
    case (state)
      ST_EMPTY: main_en = store;
      ST_ONE: begin
        main_en = store & pop;
        skid_en = store & ~pop;
      end
      ST_TWO: begin
        main_en  = pop;
        main_dv  = skid_valid;
        main_d   = skid_data;
        skid_clr = ctrl_flush | pop;
      end
      default: ;
    endcase
    main_clr = ctrl_flush | (pop & ~main_en);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset || ctrl_flush) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (store) state <= ST_ONE;
        ST_ONE: begin
          if (store && !pop) begin
            state    <= ST_TWO;
            in_ready <= 1'b0;
          end else if (pop && !store) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pipe_lane_reg #(.WIDTH(WIDTH)) u_main (
      .clock   (clock),
      .reset   (ctrl_reset),
      .clr     (main_clr),
      .en      (main_en),
      .d_valid (main_dv[k]),
      .d_data  (main_d[k*WIDTH +: WIDTH]),
      .q_valid (main_valid[k]),
      .q_data  (main_data[k*WIDTH +: WIDTH])
    );

    pipe_lane_reg #(.WIDTH(WIDTH)) u_skid (
      .clock   (clock),
      .reset   (ctrl_reset),
      .clr     (skid_clr),
      .en      (skid_en),
      .d_valid (keep[k]),
      .d_data  (in_data[k*WIDTH +: WIDTH]),
      .q_valid (skid_valid[k]),
      .q_data  (skid_data[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Bench for pipe_latch_elastic: directed scenarios plus a randomized run,
// all compared against a queue-of-bundles reference model.
module tb_pipe_latch_elastic;

  localparam int W = 115;
  localparam int L = 2;

  logic           clock = 1'b0;
  logic           ctrl_reset;
  logic           ctrl_flush;
  logic           out_ready;
  logic           in_ready;
  logic [L-1:0]   in_valid;
  logic [L-1:0]   ctrl_squash;
  logic [L-1:0]   out_valid;
  logic [L*W-1:0] in_data;
  logic [L*W-1:0] out_data;
  logic [1:0]     occupancy;

  always #5 clock = ~clock;

  pipe_latch_elastic #(.WIDTH(W), .LANES(L)) dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ctrl_squash (ctrl_squash),
    .ctrl_flush  (ctrl_flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .occupancy   (occupancy)
  );

  typedef struct {
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
  } bundle_t;

  bundle_t q[$];
  bit      m_rdy  = 1'b1;
  bit      m_push = 1'b0;
  int      checks = 0;
  int      failures = 0;

  function automatic logic [L*W-1:0] rnd_data();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[L*W-1:0];
  endfunction

  function automatic logic [L*W-1:0] lane_mask(input logic [L-1:0] v);
    logic [L*W-1:0] m;
    m = '0;
    for (int k = 0; k < L; k++) if (v[k]) m[k*W +: W] = '1;
    return m;
  endfunction

  function automatic logic [L-1:0] exp_valid();
    return (q.size() > 0) ? q[0].v : '0;
  endfunction

  function automatic logic [L*W-1:0] exp_data();
    return (q.size() > 0) ? q[0].d : '0;
  endfunction

  // Advance one clock; the model applies the handshake rules to the inputs
  // that are stable across this edge.
  task automatic step();
    bit push, pop, store;
    push = 1'b0;
    if (ctrl_reset) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      push  = (|in_valid) && m_rdy && !ctrl_flush;
      pop   = (q.size() > 0) && out_ready;
      store = push && (|(in_valid & ~ctrl_squash));
      if (ctrl_flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (store) q.push_back('{v: in_valid & ~ctrl_squash, d: in_data});
      end
      m_rdy = (q.size() < 2);
    end
    m_push = push;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_reset = 1'b0; ctrl_flush = 1'b0; ctrl_squash = '0;
    in_valid = '0; in_data = rnd_data(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [L*W-1:0] d;
    idle_inputs();
    ctrl_reset = 1'b1; in_valid = 2'b11;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 2'b00 || occupancy !== 2'd0 || out_data !== '0) begin
        failures++;
        $display("FAIL reset_state: in_ready=%b out_valid=%b occ=%0d data=%h, need 1/00/0/0",
                 in_ready, out_valid, occupancy, out_data);
      end
    end
    ctrl_reset = 1'b0; out_ready = 1'b1;
    d = '0; d[0 +: W] = W'(8'h1A); d[W +: W] = W'(8'h2B);
    in_data = d;
    step();
    checks++;
    if (m_push !== 1'b1 || out_valid !== 2'b11 || out_data !== d) begin
      failures++;
      $display("FAIL basic_push: out_valid=%b data=%h, need 11 data=%h", out_valid, out_data, d);
    end
    in_valid = '0;
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 2'b00) begin
      failures++;
      $display("FAIL basic_drain: occ=%0d out_valid=%b, need 0/00", occupancy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [L*W-1:0] da, db, dc;
    idle_inputs();
    da = rnd_data(); db = rnd_data(); dc = rnd_data();
    in_valid = 2'b11; in_data = da; step();
    in_data = db; step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== da) begin
      failures++;
      $display("FAIL skid_full: occ=%0d in_ready=%b data=%h, need 2/0 data=%h",
               occupancy, in_ready, out_data, da);
    end
    in_data = dc;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (m_push || occupancy !== 2'd2 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL skid_hold: occ=%0d in_ready=%b, need 2/0", occupancy, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_data !== db) begin
      failures++;
      $display("FAIL skid_pop_a: in_ready=%b occ=%0d data=%h, need 1/1 data=%h",
               in_ready, occupancy, out_data, db);
    end
    step();
    checks++;
    if (!m_push || occupancy !== 2'd1 || out_valid !== 2'b11 || out_data !== dc) begin
      failures++;
      $display("FAIL skid_pop_b: occ=%0d valid=%b data=%h, need 1/11 data=%h",
               occupancy, out_valid, out_data, dc);
    end
    in_valid = '0;
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 2'b00) begin
      failures++;
      $display("FAIL skid_pop_c: occ=%0d valid=%b, need 0/00", occupancy, out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
    idle_inputs();
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      v = 2'($urandom_range(1, 3));
      d = rnd_data();
      in_valid = v; in_data = d;
      step();
      checks++;
      if (!m_push || occupancy !== 2'd1 || in_ready !== 1'b1 || out_valid !== v ||
          (out_data & lane_mask(v)) !== (d & lane_mask(v))) begin
        failures++;
        $display("FAIL stream_%0d: occ=%0d valid=%b data=%h, need 1 valid=%b data=%h",
                 n, occupancy, out_valid, out_data, v, d);
      end
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_squash();
    logic [L*W-1:0] d;
    idle_inputs();
    d = rnd_data();
    in_valid = 2'b11; in_data = d; ctrl_squash = 2'b10;
    step();
    checks++;
    if (out_valid !== 2'b01 || out_data[0 +: W] !== d[0 +: W]) begin
      failures++;
      $display("FAIL squash_lane1: valid=%b lane0=%h, need 01 lane0=%h",
               out_valid, out_data[0 +: W], d[0 +: W]);
    end
    ctrl_squash = 2'b11; in_data = rnd_data();
    step();
    checks++;
    if (!m_push || occupancy !== 2'd1 || in_ready !== 1'b1 || out_valid !== 2'b01) begin
      failures++;
      $display("FAIL squash_all: push=%b occ=%0d in_ready=%b valid=%b, need 1/1/1/01",
               m_push, occupancy, in_ready, out_valid);
    end
    in_valid = '0; ctrl_squash = '0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 2'b11; in_data = rnd_data(); step();
    in_data = rnd_data(); step();
    ctrl_flush = 1'b1; out_ready = 1'b1; in_data = rnd_data();
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush: occ=%0d valid=%b in_ready=%b, need 0/00/1",
               occupancy, out_valid, in_ready);
    end
    ctrl_flush = 1'b0; in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 2'b00) begin
        failures++;
        $display("FAIL flush_after_%0d: valid=%b, need 00", c, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 2'b11; in_data = rnd_data(); step();
    in_data = rnd_data(); step();
    ctrl_reset = 1'b1; in_valid = '0;
    step();
    checks++;
    if (occupancy !== 2'd0 || out_data !== '0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: occ=%0d valid=%b in_ready=%b data=%h, need 0/00/1/0",
               occupancy, out_valid, in_ready, out_data);
    end
    ctrl_reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_after_%0d: valid=%b, need 00", c, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [L-1:0] ev;
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      ctrl_reset  = ($urandom_range(0, 63) == 0);
      ctrl_flush  = ($urandom_range(0, 15) == 0);
      ctrl_squash = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      in_valid    = 2'($urandom);
      in_data     = rnd_data();
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
      ev = exp_valid();
      checks++;
      if (occupancy !== 2'(q.size()) || in_ready !== m_rdy || out_valid !== ev ||
          (out_data & lane_mask(ev)) !== (exp_data() & lane_mask(ev))) begin
        failures++;
        $display("FAIL random_%0d: occ=%0d rdy=%b valid=%b data=%h, need %0d/%b/%b data=%h",
                 n, occupancy, in_ready, out_valid, out_data,
                 q.size(), m_rdy, ev, exp_data());
      end
    end
  endtask

  initial begin
    idle_inputs();
    ctrl_reset = 1'b1;
    test_reset();
    test_backpressure();
    test_streaming();
    test_squash();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
